// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam int unsigned X0 = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count register: clear wins over increment, hold at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding sequencer for the 5-stage RV32I pipeline, with a
// memory-wait FSM, wait-timeout watchdog and saturating performance counters.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TIMEOUT        = 64
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      LoadE,
   input  logic                      RegWriteM,
   input  logic                      RegWriteW,
   input  logic                      PCSrcE,
   input  logic                      MemReqM,
   input  logic                      MemReadyM,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      StallM,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushW,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic                      MemTimeout,
   output logic [DATA_WIDTH-1:0]     StallCount,
   output logic [DATA_WIDTH-1:0]     FlushCount
);

   localparam logic [REG_ADDR_WIDTH-1:0] REG_X0       = REG_ADDR_WIDTH'(X0);
   localparam logic [7:0]                TIMEOUT_LAST = 8'(TIMEOUT - 1);

   hz_state_t  state_r;
   hz_state_t  state_next_s;
   fwd_sel_t   fwd_a_s;
   fwd_sel_t   fwd_b_s;
   logic       lw_stall_s;
   logic       mem_miss_s;
   logic       mem_stall_s;
   logic       wait_clr_s;
   logic       wait_inc_s;
   logic       flush_any_s;
   logic [7:0] wait_cnt_s;

   // E-stage forwarding selects; the younger M result has priority over W.
   always_comb begin
      fwd_a_s = FWD_RF;
      fwd_b_s = FWD_RF;
      if (RegWriteM && (RdM != REG_X0) && (RdM == Rs1E)) begin
         fwd_a_s = FWD_MEM;
      end else if (RegWriteW && (RdW != REG_X0) && (RdW == Rs1E)) begin
         fwd_a_s = FWD_WB;
      end else begin
         fwd_a_s = FWD_RF;
      end
      if (RegWriteM && (RdM != REG_X0) && (RdM == Rs2E)) begin
         fwd_b_s = FWD_MEM;
      end else if (RegWriteW && (RdW != REG_X0) && (RdW == Rs2E)) begin
         fwd_b_s = FWD_WB;
      end else begin
         fwd_b_s = FWD_RF;
      end
   end

   assign ForwardAE = fwd_a_s;
   assign ForwardBE = fwd_b_s;

   assign lw_stall_s  = LoadE && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign mem_miss_s  = MemReqM && !MemReadyM;
   assign mem_stall_s = (state_r == MEM_WAIT) || mem_miss_s;

   // Stall/flush equations; a memory hold freezes E so branch and load-use wait.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (mem_stall_s) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall_s;
         StallD = lw_stall_s;
         FlushD = PCSrcE;
         FlushE = lw_stall_s || PCSrcE;
      end
   end

   // Memory-wait next state; a dropped request still waits for MemReadyM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         RUN: begin
            if (mem_miss_s) begin
               state_next_s = MEM_WAIT;
            end else begin
               state_next_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (MemReadyM) begin
               state_next_s = RUN;
            end else begin
               state_next_s = MEM_WAIT;
            end
         end
         default: state_next_s = RUN;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   assign wait_clr_s = (state_r == RUN) && mem_miss_s;
   assign wait_inc_s = (state_r == MEM_WAIT);

   // Sticky watchdog flag, cleared only by reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         MemTimeout <= 1'b0;
      end else if (wait_inc_s && !MemReadyM && (wait_cnt_s == TIMEOUT_LAST)) begin
         MemTimeout <= 1'b1;
      end else begin
         MemTimeout <= MemTimeout;
      end
   end

   assign flush_any_s = FlushD || FlushE;

   sat_counter #(.WIDTH(8)) u_wait_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (wait_clr_s),
      .inc   (wait_inc_s),
      .count (wait_cnt_s)
   );

   sat_counter #(.WIDTH(DATA_WIDTH)) u_stall_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (1'b0),
      .inc   (StallF),
      .count (StallCount)
   );

   sat_counter #(.WIDTH(DATA_WIDTH)) u_flush_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (1'b0),
      .inc   (flush_any_s),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table for the combinational
// equations, hand sequences for memory wait, watchdog, async reset and saturation.
module tb_hazard_controller;

   localparam int DW      = 6;
   localparam int CNT_MAX = (1 << DW) - 1;

   logic          CLK;
   logic          RST_N;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          MemTimeout;
   logic [DW-1:0] StallCount, FlushCount;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_stall_cnt = 0;
   int exp_flush_cnt = 0;

   hazard_controller #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(5), .TIMEOUT(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       loade, rwm, rww, pcsrc, memreq, memrdy;
      logic [6:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
      logic [1:0] fa, fb;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
   endtask

   // One cycle: check comb controls mid-cycle, then counters/timeout after the edge.
   task automatic cyc(input string name, input logic [6:0] ctl, input logic exp_to);
      #3;
      chk({name, "_ctl"}, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(ctl));
      if (ctl[6] && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
      if ((ctl[2] || ctl[1]) && exp_flush_cnt < CNT_MAX) exp_flush_cnt++;
      @(posedge CLK);
      #1;
      chk({name, "_stallcnt"}, 32'(StallCount), 32'(exp_stall_cnt));
      chk({name, "_flushcnt"}, 32'(FlushCount), 32'(exp_flush_cnt));
      chk({name, "_timeout"}, 32'(MemTimeout), 32'(exp_to));
   endtask

   initial begin
      vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b10, 2'b00};
      vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b01, 2'b00};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b00};
      vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b10};
      vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd4, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b01};
      vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b00};
      vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100010, 2'b00, 2'b00};
      vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b00};
      vecs[8]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100010, 2'b00, 2'b00};
      vecs[9]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b00};
      vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000110, 2'b00, 2'b00};
      vecs[11] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100110, 2'b00, 2'b00};
      vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0000000, 2'b00, 2'b00};
      vecs[13] = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b10, 2'b10};

      RST_N = 1'b0;
      clear_inputs();
      #12;
      chk("reset_stallcnt", 32'(StallCount), 32'd0);
      chk("reset_flushcnt", 32'(FlushCount), 32'd0);
      chk("reset_timeout", 32'(MemTimeout), 32'd0);
      chk("reset_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'd0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < NV; i++) begin
         {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
            {vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1e, vecs[i].rs2e, vecs[i].rde, vecs[i].rdm, vecs[i].rdw};
         {LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} =
            {vecs[i].loade, vecs[i].rwm, vecs[i].rww, vecs[i].pcsrc, vecs[i].memreq, vecs[i].memrdy};
         #2;
         chk($sformatf("vec%0d_fwda", i), 32'(ForwardAE), 32'(vecs[i].fa));
         chk($sformatf("vec%0d_fwdb", i), 32'(ForwardBE), 32'(vecs[i].fb));
         #1;
         cyc($sformatf("vec%0d", i), vecs[i].ctl, 1'b0);
      end

      // Memory miss: three low cycles then ready; branch and load-use held off.
      clear_inputs();
      MemReqM = 1'b1; PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
      for (int c = 1; c <= 4; c++) begin
         MemReadyM = (c == 4);
         cyc($sformatf("miss_c%0d", c), 7'b1111001, 1'b0);
      end
      MemReqM = 1'b0; MemReadyM = 1'b0; LoadE = 1'b0;
      cyc("miss_c5_run", 7'b0000110, 1'b0);

      // Watchdog with TIMEOUT=4: flag rises after the 4th MEM_WAIT cycle and sticks.
      clear_inputs();
      MemReqM = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         cyc($sformatf("to_c%0d", c), 7'b1111001, (c == 5));
      end
      MemReqM = 1'b0;
      cyc("to_c6_reqdrop", 7'b1111001, 1'b1);
      MemReqM = 1'b1; MemReadyM = 1'b1;
      cyc("to_c7_ready", 7'b1111001, 1'b1);
      MemReqM = 1'b0; MemReadyM = 1'b0;
      cyc("to_c8_run", 7'b0000000, 1'b1);

      // Asynchronous reset while waiting, between clock edges.
      MemReqM = 1'b1;
      cyc("rst_enter", 7'b1111001, 1'b1);
      MemReqM = 1'b0;
      #1;
      chk("rst_pre_wait", 32'(StallF), 32'd1);
      RST_N = 1'b0;
      #1;
      chk("rst_async_state", 32'(StallF), 32'd0);
      chk("rst_async_timeout", 32'(MemTimeout), 32'd0);
      chk("rst_async_stallcnt", 32'(StallCount), 32'd0);
      chk("rst_async_flushcnt", 32'(FlushCount), 32'd0);
      #1;
      RST_N = 1'b1;
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
      @(posedge CLK);
      #1;

      // Saturation: sustained load-use stalls drive both counters past all-ones.
      clear_inputs();
      LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
      for (int c = 0; c < CNT_MAX + 6; c++) begin
         cyc("sat", 7'b1100010, 1'b0);
      end
      chk("sat_stall_max", 32'(StallCount), 32'(CNT_MAX));
      chk("sat_flush_max", 32'(FlushCount), 32'(CNT_MAX));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage RV32I core.
- Drives the stall (EN) and flush (CLR) controls of the F/D, D/E, E/M and M/W pipeline registers.
- Generates the E-stage forwarding selects.
- Holds the whole pipeline through multi-cycle data-memory waits using a small FSM with a wait-timeout watchdog, and keeps saturating stall/flush performance counters.

Parameters:
- DATA_WIDTH, 32, width of the performance counters.
- REG_ADDR_WIDTH, 5, register-index width.
- TIMEOUT, 64, number of MEM_WAIT cycles before MemTimeout is raised. Legal range 2..255.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- Rs1D, Rs2D  input  REG_ADDR_WIDTH  source registers of the instruction in Decode.
- Rs1E, Rs2E  input  REG_ADDR_WIDTH  source registers of the instruction in Execute.
- RdE, RdM, RdW  input  REG_ADDR_WIDTH  destination registers in E, M and W.
- LoadE  input  1  instruction in E is a load (ResultSrcE selects memory).
- RegWriteM, RegWriteW  input  1  register-file write enables in M and W.
- PCSrcE  input  1  taken branch or jump resolved in E.
- MemReqM  input  1  load or store active in M.
- MemReadyM  input  1  data memory completes the M access this cycle.
- StallF, StallD, StallE, StallM  output  1  active-high hold; wired to the EN of the corresponding pipeline register.
- FlushD, FlushE, FlushW  output  1  active-high bubble insert; wired to CLR.
- ForwardAE, ForwardBE  output  2  00 = register file, 10 = ALUResultM, 01 = ResultW.
- MemTimeout  output  1  sticky watchdog flag.
- StallCount, FlushCount  output  DATA_WIDTH  performance counters.

Behaviour:
- Reset: RST_N low asynchronously forces state RUN, wait counter 0, MemTimeout 0, StallCount 0, FlushCount 0.
- Stall/flush/forward outputs are combinational from inputs and state. During reset they evaluate with state RUN.
- Forwarding, per operand A (B identical using Rs2E):
  - 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
  - else 01 if RegWriteW, RdW != 0 and RdW == Rs1E.
  - else 00.
  - M has priority over W.
- lwStall = LoadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
- MemStall = (state == MEM_WAIT) or (MemReqM and not MemReadyM). The same-cycle term makes the first miss cycle stall with zero latency.
- Stall and flush equations, in priority order:
  - If MemStall:
    - StallF = StallD = StallE = StallM = 1.
    - FlushW = 1, so W retires a bubble.
    - FlushD = FlushE = 0. Branch and load-use hazards are suppressed because E is frozen; they re-evaluate on the release cycle.
  - Else:
    - StallF = StallD = lwStall.
    - StallE = StallM = FlushW = 0.
    - FlushD = PCSrcE.
    - FlushE = lwStall or PCSrcE.
    - If lwStall and PCSrcE occur together: F/D stall and flush E. FlushD also asserts, and the fetched-wrong-path instruction is discarded.
- FSM:
  - RUN -> MEM_WAIT when MemReqM and not MemReadyM.
  - MEM_WAIT -> RUN on the cycle MemReadyM = 1. Outputs in that cycle are still MemStall. Normal flow resumes the next cycle.
  - MemReqM dropping in MEM_WAIT is a protocol error. The FSM stays in MEM_WAIT until MemReadyM.
- Watchdog:
  - Wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When it reaches TIMEOUT-1 with MemReadyM low, MemTimeout sets. It stays set until reset.
  - The counter saturates, and the FSM keeps waiting.
- Counters:
  - StallCount increments on every cycle with StallF = 1.
  - FlushCount increments on every cycle with FlushD or FlushE.
  - Both saturate at all-ones; there is no wrap.

Decomposition:
- Package hazard_pkg holds:
  - typedef fwd_sel_t (2-bit enum FWD_RF, FWD_WB, FWD_MEM);
  - typedef hz_state_t (RUN, MEM_WAIT);
  - constant X0 = 0.
- One sub-module, sat_counter, parameterised by width with inc input and count output. It is instantiated for StallCount, FlushCount and the wait counter.
- Forwarding and hazard equations stay in the top-level module.

Test Plan:
- Forwarding priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. Set Rs1E = 0 -> ForwardAE = 00.
- Load-use: LoadE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle, StallCount +1. With RdE = 0 -> no stall.
- Branch: PCSrcE = 1 for one cycle -> FlushD = FlushE = 1, FlushCount +1, no stalls.
- Memory miss: MemReqM = 1 with MemReadyM low for 3 cycles, then high -> all four stalls and FlushW high for 4 cycles, FlushD/FlushE = 0 throughout even with PCSrcE = 1, FSM back to RUN on cycle 5.
- Timeout: TIMEOUT = 4, MemReadyM held low for 6 cycles -> MemTimeout rises at end of the 4th wait cycle and stays set after MemReadyM.
- Reset mid-wait: RST_N pulsed low in MEM_WAIT with counters non-zero -> state RUN, counters 0, MemTimeout 0 immediately, without waiting for a clock edge.
